// File: rtl/ladybird_bus_router_pkg.sv
// Shared configuration for the ladybird bus router: peripheral enumeration,
// the default nibble-decoded region map and the route FIFO entry layout.
package ladybird_config;

  localparam int NUM_PERIPHERAL = 6;
  localparam int CFG_XLEN       = 32;

  typedef enum logic [2:0] {
    ACC_IRAM = 3'd0,
    ACC_BRAM = 3'd1,
    ACC_DRAM = 3'd2,
    ACC_UART = 3'd3,
    ACC_QSPI = 3'd4,
    ACC_GPIO = 3'd5
  } access_t;

  // Index 0 (IRAM) is the rightmost element of each packed table.
  localparam logic [NUM_PERIPHERAL-1:0][CFG_XLEN-1:0] DEFAULT_REGION_BASE = {
    32'hE000_0000,  // GPIO
    32'hD000_0000,  // QSPI
    32'hF000_0000,  // UART
    32'h0000_0000,  // DRAM
    32'h8000_0000,  // BRAM
    32'h9000_0000   // IRAM
  };

  localparam logic [NUM_PERIPHERAL-1:0][CFG_XLEN-1:0] DEFAULT_REGION_MASK =
    {NUM_PERIPHERAL{32'hF000_0000}};

  typedef struct packed {
    logic    error;
    access_t ch;
  } route_entry_t;

endpackage

// File: rtl/ladybird_route_fifo.sv
// Synchronous FIFO holding the routing decision of every in-flight request.
// Full/empty derive from the registered count, so a same-cycle pop never frees a slot early.
module ladybird_route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ladybird_bus_router.sv
// Single-master request router: decodes each request against a base/mask region
// table, forwards it to one peripheral channel and returns responses in order.
module ladybird_bus_router
  import ladybird_config::*;
#(
  parameter int                            XLEN            = 32,
  parameter int                            NUM_CH          = NUM_PERIPHERAL,
  parameter int                            MAX_OUTSTANDING = 4,
  parameter logic [NUM_CH-1:0][XLEN-1:0]   REGION_BASE     = DEFAULT_REGION_BASE,
  parameter logic [NUM_CH-1:0][XLEN-1:0]   REGION_MASK     = DEFAULT_REGION_MASK,
  parameter bit                            DEFAULT_EN      = 1'b1,
  parameter int                            DEFAULT_CH      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  // Every handshake transfers exactly on a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready of the same interface.
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [XLEN-1:0]                req_addr,
  input  logic [XLEN-1:0]                req_wdata,
  input  logic [XLEN/8-1:0]              req_wstrb,
  input  logic                           req_write,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [XLEN-1:0]                resp_data,
  output logic                           resp_error,
  output logic [NUM_CH-1:0]              ch_req_valid,
  input  logic [NUM_CH-1:0]              ch_req_ready,
  output logic [XLEN-1:0]                ch_req_addr,
  output logic [XLEN-1:0]                ch_req_wdata,
  output logic [XLEN/8-1:0]              ch_req_wstrb,
  output logic                           ch_req_write,
  input  logic [NUM_CH-1:0]              ch_resp_valid,
  output logic [NUM_CH-1:0]              ch_resp_ready,
  input  logic [NUM_CH-1:0][XLEN-1:0]    ch_resp_data
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W = CH_W + 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CH_W-1:0]  dec_ch;
  logic             dec_hit;
  logic             dec_err;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] last_q;
  logic             same_target;
  logic             can_issue;
  logic             req_fire;
  logic             resp_fire;

  logic [ENT_W-1:0] head_entry;
  logic             head_err;
  logic [CH_W-1:0]  head_ch;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Walk from the top index down so the lowest-index hit is the one that sticks.
  always_comb begin
    dec_ch  = CH_W'(DEFAULT_CH);
    dec_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((req_addr & REGION_MASK[i]) == REGION_BASE[i]) begin
        dec_hit = 1'b1;
        dec_ch  = CH_W'(i);
      end
    end
    dec_err = ~dec_hit & ~DEFAULT_EN;
  end

  // Error entries carry channel 0 so that "error" compares as a single target.
  assign push_entry  = {dec_err, (dec_err ? {CH_W{1'b0}} : dec_ch)};
  assign same_target = (push_entry == last_q);
  assign can_issue   = ~fifo_full & (fifo_empty | same_target);

  assign req_ready = can_issue & (dec_err | ch_req_ready[dec_ch]);
  assign req_fire  = req_valid & req_ready;

  always_comb begin
    ch_req_valid = '0;
    if (!dec_err) begin
      ch_req_valid[dec_ch] = req_valid & can_issue;
    end
  end

  assign ch_req_addr  = req_addr;
  assign ch_req_wdata = req_wdata;
  assign ch_req_wstrb = req_wstrb;
  assign ch_req_write = req_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= '0;
    end else if (req_fire) begin
      last_q <= push_entry;
    end
  end

  ladybird_route_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ENT_W)
  ) u_route_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_fire),
    .push_data_i (push_entry),
    .pop_i       (resp_fire),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head_err = head_entry[CH_W];
  assign head_ch  = head_entry[CH_W-1:0];

  // Only the head channel ever sees ready, so later channels cannot overtake it.
  always_comb begin
    resp_valid    = 1'b0;
    resp_data     = '0;
    resp_error    = 1'b0;
    ch_resp_ready = '0;
    if (fifo_count != '0) begin
      if (head_err) begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
      end else begin
        resp_valid             = ch_resp_valid[head_ch];
        resp_data              = ch_resp_data[head_ch];
        ch_resp_ready[head_ch] = resp_ready;
      end
    end
  end

  assign resp_fire = resp_valid & resp_ready;

endmodule

// File: tb/tb_ladybird_bus_router.sv
// Randomised scoreboard bench for ladybird_bus_router: instance 0 uses the default
// map with DRAM fallback, instance 1 has DRAM unmapped, overlapping ch0/ch1 and decode errors.
module tb_ladybird_bus_router;

  localparam int NCH  = 6;
  localparam int MAXO = 4;
  localparam int ERRT = 6;

  localparam logic [NCH-1:0][31:0] B1 = {32'hE000_0000, 32'hD000_0000, 32'hF000_0000,
                                         32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
  localparam logic [NCH-1:0][31:0] M1 = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                         32'h0000_0000, 32'hFF00_0000, 32'hF000_0000};

  typedef struct {
    logic        err;
    int          ch;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic                 req_valid     [2];
  logic                 req_ready     [2];
  logic [31:0]          req_addr      [2];
  logic [31:0]          req_wdata     [2];
  logic [3:0]           req_wstrb     [2];
  logic                 req_write     [2];
  logic                 resp_valid    [2];
  logic                 resp_ready    [2];
  logic [31:0]          resp_data     [2];
  logic                 resp_error    [2];
  logic [NCH-1:0]       ch_req_valid  [2];
  logic [NCH-1:0]       ch_req_ready  [2];
  logic [31:0]          ch_req_addr   [2];
  logic [31:0]          ch_req_wdata  [2];
  logic [3:0]           ch_req_wstrb  [2];
  logic                 ch_req_write  [2];
  logic [NCH-1:0]       ch_resp_valid [2];
  logic [NCH-1:0]       ch_resp_ready [2];
  logic [NCH-1:0][31:0] ch_resp_data  [2];

  logic [31:0] base_t [2][NCH];
  logic [31:0] mask_t [2][NCH];

  exp_t        exp_q [2][$];
  int          tgt_q [2][$];
  logic [31:0] pq    [2*NCH][$];

  logic acc       [2];
  logic hold      [2];
  logic force_rdy [2];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ladybird_bus_router u_dut0 (
    .clk (clk), .reset (reset),
    .req_valid (req_valid[0]), .req_ready (req_ready[0]), .req_addr (req_addr[0]),
    .req_wdata (req_wdata[0]), .req_wstrb (req_wstrb[0]), .req_write (req_write[0]),
    .resp_valid (resp_valid[0]), .resp_ready (resp_ready[0]), .resp_data (resp_data[0]),
    .resp_error (resp_error[0]),
    .ch_req_valid (ch_req_valid[0]), .ch_req_ready (ch_req_ready[0]),
    .ch_req_addr (ch_req_addr[0]), .ch_req_wdata (ch_req_wdata[0]),
    .ch_req_wstrb (ch_req_wstrb[0]), .ch_req_write (ch_req_write[0]),
    .ch_resp_valid (ch_resp_valid[0]), .ch_resp_ready (ch_resp_ready[0]),
    .ch_resp_data (ch_resp_data[0])
  );

  ladybird_bus_router #(
    .REGION_BASE (B1), .REGION_MASK (M1), .DEFAULT_EN (1'b0), .DEFAULT_CH (2)
  ) u_dut1 (
    .clk (clk), .reset (reset),
    .req_valid (req_valid[1]), .req_ready (req_ready[1]), .req_addr (req_addr[1]),
    .req_wdata (req_wdata[1]), .req_wstrb (req_wstrb[1]), .req_write (req_write[1]),
    .resp_valid (resp_valid[1]), .resp_ready (resp_ready[1]), .resp_data (resp_data[1]),
    .resp_error (resp_error[1]),
    .ch_req_valid (ch_req_valid[1]), .ch_req_ready (ch_req_ready[1]),
    .ch_req_addr (ch_req_addr[1]), .ch_req_wdata (ch_req_wdata[1]),
    .ch_req_wstrb (ch_req_wstrb[1]), .ch_req_write (ch_req_write[1]),
    .ch_resp_valid (ch_resp_valid[1]), .ch_resp_ready (ch_resp_ready[1]),
    .ch_resp_data (ch_resp_data[1])
  );

  // ---------------- reference model helpers ----------------
  function automatic int model_target(input int d, input logic [31:0] a);
    for (int i = 0; i < NCH; i++) begin
      if ((a & mask_t[d][i]) == base_t[d][i]) return i;
    end
    return (d == 0) ? 2 : ERRT;
  endfunction

  function automatic logic [31:0] pdata(input logic [31:0] a, input logic [31:0] w, input int c);
    logic [31:0] k;
    k = 32'h9E37_79B9 * 32'(c + 1);
    return a ^ {w[15:0], w[31:16]} ^ k;
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @cyc %0d: got 0x%0h, expected 0x%0h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- request-side monitor: predicts issue, pushes expectations ----------------
  always @(negedge clk) begin
    int          tgt;
    logic        can;
    logic        exp_rdy;
    logic [NCH-1:0] exp_cv;
    exp_t        e;
    cyc++;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (req_valid[d]) begin
          tgt     = model_target(d, req_addr[d]);
          can     = (tgt_q[d].size() < MAXO) && (tgt_q[d].size() == 0 || tgt_q[d][$] == tgt);
          exp_rdy = can && (tgt == ERRT || ch_req_ready[d][tgt]);
          exp_cv  = '0;
          if (tgt != ERRT && can) exp_cv[tgt] = 1'b1;
          chk("req_ready", d, 64'(req_ready[d]), 64'(exp_rdy));
          chk("ch_req_valid", d, 64'(ch_req_valid[d]), 64'(exp_cv));
          chk("ch_req_fields", d, {ch_req_addr[d], ch_req_wstrb[d], ch_req_write[d]},
              {req_addr[d], req_wstrb[d], req_write[d]});
          chk("ch_req_wdata", d, 64'(ch_req_wdata[d]), 64'(req_wdata[d]));
          if (req_ready[d]) begin
            e.err  = (tgt == ERRT);
            e.ch   = tgt;
            e.data = e.err ? 32'h0 : pdata(req_addr[d], req_wdata[d], tgt);
            e.cyc  = cyc;
            exp_q[d].push_back(e);
            tgt_q[d].push_back(tgt);
            acc[d] = 1'b1;
          end
        end else begin
          chk("ch_req_idle", d, 64'(ch_req_valid[d]), 64'h0);
        end
      end
    end
  end

  // ---------------- response monitor + peripheral bookkeeping ----------------
  always @(negedge clk) begin
    exp_t           h;
    logic           in_dut;
    logic           exp_v;
    logic [NCH-1:0] exp_crr;
    #1;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        in_dut  = (exp_q[d].size() > 0) && (exp_q[d][0].cyc != cyc);
        exp_v   = 1'b0;
        exp_crr = '0;
        h.err   = 1'b0;
        if (in_dut) begin
          h = exp_q[d][0];
          if (h.err) begin
            exp_v = 1'b1;
          end else begin
            exp_v       = ch_resp_valid[d][h.ch];
            exp_crr[h.ch] = resp_ready[d];
          end
        end
        chk("resp_valid", d, 64'(resp_valid[d]), 64'(exp_v));
        chk("ch_resp_ready", d, 64'(ch_resp_ready[d]), 64'(exp_crr));
        if (!resp_valid[d]) chk("resp_error_idle", d, 64'(resp_error[d]), 64'h0);
        if (in_dut && resp_valid[d] && resp_ready[d]) begin
          void'(exp_q[d].pop_front());
          void'(tgt_q[d].pop_front());
          chk("resp_data", d, 64'(resp_data[d]), 64'(h.data));
          chk("resp_error", d, 64'(resp_error[d]), 64'(h.err));
        end
        for (int c = 0; c < NCH; c++) begin
          if (ch_resp_valid[d][c] && ch_resp_ready[d][c] && pq[d*NCH+c].size() > 0)
            void'(pq[d*NCH+c].pop_front());
          if (ch_req_valid[d][c] && ch_req_ready[d][c])
            pq[d*NCH+c].push_back(pdata(ch_req_addr[d], ch_req_wdata[d], c));
        end
      end
    end
  end

  // ---------------- peripheral and master-response drivers ----------------
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        ch_req_ready[d][c] = force_rdy[d] ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (pq[d*NCH+c].size() > 0 && !hold[d] && $urandom_range(0, 3) != 0) begin
          ch_resp_valid[d][c] = 1'b1;
          ch_resp_data[d][c]  = pq[d*NCH+c][0];
        end else begin
          ch_resp_valid[d][c] = 1'b0;
          ch_resp_data[d][c]  = $urandom;
        end
      end
      resp_ready[d] = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      tgt_q[d].delete();
      acc[d] = 1'b0;
    end
    for (int i = 0; i < 2*NCH; i++) pq[i].delete();
    reset = 1'b0;
  endtask

  task automatic present(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] st);
    acc[d]       = 1'b0;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_write[d] = w;
    req_wdata[d] = wd;
    req_wstrb[d] = st;
  endtask

  task automatic wait_acc(input int d, input int budget);
    int n = 0;
    while (!acc[d] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!acc[d]) begin
      n_bad++;
      $display("FAIL accept_timeout dut%0d addr 0x%0h: not accepted within %0d cycles", d, req_addr[d], budget);
    end
    acc[d] = 1'b0;
  endtask

  task automatic issue(input int d, input logic [31:0] a);
    present(d, a, 1'b0, $urandom, 4'hF);
    wait_acc(d, 200);
  endtask

  task automatic idle(input int d);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (exp_q[d].size() > 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (exp_q[d].size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout dut%0d: %0d responses never returned", d, exp_q[d].size());
    end
  endtask

  task automatic rand_traffic(input int d, input int n);
    logic [3:0] nibs [8];
    logic [3:0] nib;
    nibs = '{4'h9, 4'h8, 4'h0, 4'hF, 4'hD, 4'hE, 4'h4, 4'h1};
    nib  = 4'h8;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 0) nib = nibs[$urandom_range(0, 7)];
      present(d, {nib, 28'($urandom)}, 1'($urandom), $urandom, 4'($urandom));
      wait_acc(d, 300);
      if ($urandom_range(0, 3) == 0) begin
        idle(d);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    idle(d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    base_t[0] = '{32'h9000_0000, 32'h8000_0000, 32'h0000_0000, 32'hF000_0000, 32'hD000_0000, 32'hE000_0000};
    mask_t[0] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    base_t[1] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF000_0000, 32'hD000_0000, 32'hE000_0000};
    mask_t[1] = '{32'hF000_0000, 32'hFF00_0000, 32'h0000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0; req_wstrb[d] = '0;
      req_write[d] = 1'b0; resp_ready[d] = 1'b0; ch_req_ready[d] = '0;
      ch_resp_valid[d] = '0; ch_resp_data[d] = '0;
      acc[d] = 1'b0; hold[d] = 1'b0; force_rdy[d] = 1'b1;
    end

    do_reset(3);
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_resp_valid", d, 64'(resp_valid[d]), 64'h0);
      chk("reset_resp_error", d, 64'(resp_error[d]), 64'h0);
      chk("reset_ch_req_valid", d, 64'(ch_req_valid[d]), 64'h0);
      chk("reset_ch_resp_ready", d, 64'(ch_resp_ready[d]), 64'h0);
    end
    @(posedge clk);
    #1;

    // IRAM read on the default map
    issue(0, 32'h9000_0010);
    idle(0);
    wait_drain(0);

    // Unmapped address with fallback disabled: error response the next cycle
    issue(1, 32'h4000_0000);
    idle(1);
    @(negedge clk);
    #2;
    chk("err_resp_valid", 1, 64'(resp_valid[1]), 64'h1);
    chk("err_resp_error", 1, 64'(resp_error[1]), 64'h1);
    chk("err_resp_data", 1, 64'(resp_data[1]), 64'h0);
    chk("err_no_channel", 1, 64'(ch_req_valid[1]), 64'h0);
    @(posedge clk);
    #1;
    wait_drain(1);

    // Overlapping regions: 0x8000_0000 goes to ch0 on instance 1
    issue(1, 32'h8000_0000);
    idle(1);
    wait_drain(1);

    // Four outstanding BRAM reads fill the table; a fifth stalls until a pop
    hold[0] = 1'b1;
    for (int k = 0; k < 4; k++) issue(0, 32'h8000_0000 + 32'(k * 4));
    present(0, 32'h8000_0040, 1'b0, 32'h0, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    chk("fifth_stalled", 0, 64'(acc[0]), 64'h0);
    hold[0] = 1'b0;
    wait_acc(0, 100);
    idle(0);
    wait_drain(0);

    // Target switch BRAM -> UART waits for the BRAM response
    hold[0] = 1'b1;
    issue(0, 32'h8000_0100);
    present(0, 32'hF000_0000, 1'b0, 32'h0, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    chk("switch_stalled", 0, 64'(acc[0]), 64'h0);
    hold[0] = 1'b0;
    wait_acc(0, 100);
    idle(0);
    wait_drain(0);

    // Reset with three outstanding entries drops them all
    hold[0] = 1'b1;
    for (int k = 0; k < 3; k++) issue(0, 32'hE000_0000 + 32'(k * 4));
    idle(0);
    do_reset(1);
    hold[0] = 1'b0;
    @(negedge clk);
    #2;
    chk("post_reset_resp_valid", 0, 64'(resp_valid[0]), 64'h0);
    chk("post_reset_ch_resp_ready", 0, 64'(ch_resp_ready[0]), 64'h0);
    @(posedge clk);
    #1;
    present(0, 32'hE000_0000, 1'b0, 32'h0, 4'hF);
    wait_acc(0, 1);
    idle(0);
    wait_drain(0);

    // Randomised traffic on both instances concurrently
    force_rdy[0] = 1'b0;
    force_rdy[1] = 1'b0;
    fork
      rand_traffic(0, 600);
      rand_traffic(1, 600);
    join
    wait_drain(0);
    wait_drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
